pie_encoder: RTL and testbench
==============================

PIE_ENCODER -- requirements
Module: pie_encoder

Interface
REQ-001 SHALL have parameter TARI_CYCLES, default 25, clocks per data-0 symbol (Tari).
REQ-002 SHALL have parameter DATA1_CYCLES, default 44, clocks per data-1 symbol.
REQ-003 SHALL have parameter PW_CYCLES, default 12, clocks of the low pulse ending every symbol.
REQ-004 SHALL have parameter DELIM_CYCLES, default 25, clocks of the frame-start delimiter.
REQ-005 SHALL have parameter LEN_WIDTH, default 8, width of cmd_len.
REQ-006 SHALL have parameter TRCAL_WIDTH, default 9, width of trcal_cycles.
REQ-007 clk  input  1  single clock; all logic on rising edge.
REQ-008 rst  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  one-cycle frame request.
REQ-010 preamble  input  1  1 = full preamble including TRcal (Query), 0 = frame-sync; sampled with start.
REQ-011 cmd_len  input  LEN_WIDTH  command bit count; sampled with start.
REQ-012 trcal_cycles  input  TRCAL_WIDTH  TRcal length in clocks; sampled with start.
REQ-013 in_dat  input  1  next command bit, MSB first.
REQ-014 in_vld  input  1  in_dat valid.
REQ-015 in_rdy  output  1  encoder consumes in_dat this cycle.
REQ-016 out_dat  output  1  carrier envelope: 1 = carrier on, 0 = modulated low.
REQ-017 busy  output  1  frame in progress.
REQ-018 done  output  1  one-cycle pulse at frame end.
REQ-019 err  output  1  valid with done; 1 = bit underrun abort.

Function
REQ-020 States SHALL be IDLE, DELIM, DATA0, RTCAL, TRCAL, BITS, END.
REQ-021 IDLE: out_dat=1, busy=0; start=1 SHALL latch preamble/cmd_len/trcal_cycles and enter DELIM; out_dat=0 the cycle after start.
REQ-022 start while busy=1 SHALL be ignored.
REQ-023 DELIM: out_dat=0 for DELIM_CYCLES clocks, then DATA0.
REQ-024 Every symbol of length L SHALL be out_dat=1 for L-PW_CYCLES clocks, then 0 for PW_CYCLES clocks; symbols back-to-back, no gap.
REQ-025 DATA0: one symbol, L=TARI_CYCLES; then RTCAL.
REQ-026 RTCAL: L=TARI_CYCLES+DATA1_CYCLES; then TRCAL if preamble=1, else BITS (END if cmd_len=0).
REQ-027 TRCAL: L=trcal_cycles; then BITS, or END if cmd_len=0.
REQ-028 BITS: in_rdy=1 only in the first clock of each data symbol; in_vld=1 there SHALL consume in_dat, L=TARI_CYCLES if 0, DATA1_CYCLES if 1.
REQ-029 in_vld=0 when in_rdy=1 SHALL abort: out_dat=1 next cycle, enter END with err=1.
REQ-030 After the cmd_len-th symbol completes, SHALL enter END.
REQ-031 END: out_dat=1, done=1 for one cycle, busy=0 next cycle, return to IDLE; err=0 unless REQ-029.
REQ-032 busy=1 in every state except IDLE; start in the same cycle as done SHALL be ignored.
REQ-033 Symbol counter SHALL be wide enough for max(DELIM_CYCLES, TARI+DATA1, 2^TRCAL_WIDTH-1); trcal_cycles<=PW_CYCLES is illegal, behaviour unspecified.
REQ-034 Bit counter SHALL count down from cmd_len, LEN_WIDTH bits, no wrap.

Reset
REQ-035 rst=0 SHALL asynchronously force state IDLE, out_dat=1, busy=0, done=0, err=0, in_rdy=0, counters 0.
REQ-036 Reset mid-frame SHALL discard the frame with no done pulse; operation resumes on first clock after rst=1.

Structure
REQ-037 Shared package pie_pkg SHALL hold the state enum and default timing constants.
REQ-038 Sub-module pie_symbol_timer SHALL generate one symbol (length L, PW) and a symbol-end strobe; the FSM SHALL sequence it.

Verification
REQ-039 Frame-sync, cmd_len=0 -> out_dat low 25, high 13, low 12, high 57, low 12, then done=1, err=0.
REQ-040 Preamble, trcal_cycles=150, cmd_len=0 -> as REQ-039 plus high 138, low 12 before done.
REQ-041 Frame-sync, cmd_len=2, bits 1,0 always valid -> after RTcal: high 32, low 12, high 13, low 12; in_rdy pulsed twice; done, err=0.
REQ-042 cmd_len=3, in_vld dropped at second fetch -> out_dat=1 next cycle, done=1 with err=1, only one in_rdy handshake.
REQ-043 rst=0 mid-TRCAL -> out_dat=1 and busy=0 immediately, no done; new start after release gives a clean frame.
REQ-044 start pulsed during BITS and coincident with done -> ignored; frame timing unchanged.

Source files
------------

// File: rtl/pie_pkg.sv
// pie_pkg: shared definitions for the PIE (pulse-interval encoding) encoder.
//   - pie_state_t : frame sequencer states
//   - *_DEF       : default symbol timing (in clocks) and field widths
//   - max3        : helper used to size the symbol counter
package pie_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DELIM,
        DATA0,
        RTCAL,
        TRCAL,
        BITS,
        END
    } pie_state_t;

    localparam int TARI_DEF    = 25;
    localparam int DATA1_DEF   = 44;
    localparam int PW_DEF      = 12;
    localparam int DELIM_DEF   = 25;
    localparam int LEN_W_DEF   = 8;
    localparam int TRCAL_W_DEF = 9;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pie_symbol_timer.sv
// pie_symbol_timer: times one symbol of len clocks. The envelope is high for
// len-PW_CYCLES clocks and low for the final PW_CYCLES clocks.
//   clk, rst : clock, asynchronous active-low reset
//   en       : counter advances while a frame is active
//   go       : first clock of a new symbol; len is taken from the port this cycle
//   len      : symbol length in clocks (must exceed PW_CYCLES)
//   level    : envelope level for the current clock
//   sym_end  : last clock of the current symbol
module pie_symbol_timer
    import pie_pkg::*;
#(
    parameter int CNT_W     = 9,
    parameter int PW_CYCLES = PW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             go,
    input  logic [CNT_W-1:0] len,
    output logic             level,
    output logic             sym_end
);

    logic [CNT_W-1:0] cnt, len_r;
    logic [CNT_W-1:0] c, l;
    logic [CNT_W:0]   c_pw;

    // On go the symbol starts at position 0 with the new length, so the
    // first clock's level/end are valid without a preload cycle. This lets a
    // data bit's length be chosen in the same clock its bit is consumed.
    always_comb begin
        c = go ? '0  : cnt;
        l = go ? len : len_r;
    end

    assign c_pw    = {1'b0, c} + (CNT_W+1)'(PW_CYCLES);
    assign level   = c_pw < {1'b0, l};
    assign sym_end = (c == l - CNT_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            len_r <= '0;
        end else if (en) begin
            cnt   <= c + CNT_W'(1);
            len_r <= l;
        end
    end

endmodule

// File: rtl/pie_encoder.sv
// pie_encoder: reader-to-tag PIE frame generator.
// Frame: delimiter (low), data-0, RTcal, optional TRcal, then cmd_len data
// symbols fetched MSB first from a valid/ready bit stream.
//   clk, rst      : clock, asynchronous active-low reset
//   start         : one-cycle frame request (ignored unless idle)
//   preamble      : 1 = include TRcal; sampled with start
//   cmd_len       : number of command bits; sampled with start
//   trcal_cycles  : TRcal length in clocks; sampled with start
//   in_dat/in_vld : command bit stream; in_rdy marks the fetch clock
//   out_dat       : carrier envelope (1 = carrier on)
//   busy          : frame in progress
//   done, err     : end-of-frame pulse; err = aborted on bit underrun
module pie_encoder
    import pie_pkg::*;
#(
    parameter int TARI_CYCLES  = TARI_DEF,
    parameter int DATA1_CYCLES = DATA1_DEF,
    parameter int PW_CYCLES    = PW_DEF,
    parameter int DELIM_CYCLES = DELIM_DEF,
    parameter int LEN_WIDTH    = LEN_W_DEF,
    parameter int TRCAL_WIDTH  = TRCAL_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   preamble,
    input  logic [LEN_WIDTH-1:0]   cmd_len,
    input  logic [TRCAL_WIDTH-1:0] trcal_cycles,
    input  logic                   in_dat,
    input  logic                   in_vld,
    output logic                   in_rdy,
    output logic                   out_dat,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int SYM_MAX = max3(DELIM_CYCLES, TARI_CYCLES + DATA1_CYCLES,
                                  2**TRCAL_WIDTH - 1);
    localparam int CNT_W   = $clog2(SYM_MAX + 1);

    pie_state_t             state, state_nxt;
    logic                   preamble_r;
    logic [TRCAL_WIDTH-1:0] trcal_r;
    logic [LEN_WIDTH-1:0]   bit_cnt;
    logic                   err_r, err_nxt;
    logic                   sym_first, first_nxt;
    logic [CNT_W-1:0]       sym_len;
    logic                   level, sym_end;
    logic                   consume;

    pie_symbol_timer #(
        .CNT_W     (CNT_W),
        .PW_CYCLES (PW_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .en      (state != IDLE),
        .go      (sym_first),
        .len     (sym_len),
        .level   (level),
        .sym_end (sym_end)
    );

    assign in_rdy  = (state == BITS) && sym_first;
    assign consume = in_rdy && in_vld;
    assign busy    = (state != IDLE);
    assign done    = (state == END);
    assign err     = (state == END) && err_r;

    // The bit length is picked from in_dat in the fetch clock; on an
    // underrun the length is irrelevant since the frame ends next clock.
    always_comb begin
        sym_len = CNT_W'(TARI_CYCLES);
        case (state)
            DELIM:   sym_len = CNT_W'(DELIM_CYCLES);
            RTCAL:   sym_len = CNT_W'(TARI_CYCLES + DATA1_CYCLES);
            TRCAL:   sym_len = CNT_W'(trcal_r);
            BITS:    sym_len = in_dat ? CNT_W'(DATA1_CYCLES) : CNT_W'(TARI_CYCLES);
            default: ;
        endcase
    end

    always_comb begin
        out_dat = 1'b1;
        case (state)
            DELIM:                     out_dat = 1'b0;
            DATA0, RTCAL, TRCAL, BITS: out_dat = level;
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        err_nxt   = err_r;
        case (state)
            IDLE: if (start) begin
                state_nxt = DELIM;
                err_nxt   = 1'b0;
            end
            DELIM: if (sym_end) state_nxt = DATA0;
            DATA0: if (sym_end) state_nxt = RTCAL;
            RTCAL: if (sym_end) begin
                if (preamble_r)         state_nxt = TRCAL;
                else if (bit_cnt == '0) state_nxt = END;
                else                    state_nxt = BITS;
            end
            TRCAL: if (sym_end) state_nxt = (bit_cnt == '0) ? END : BITS;
            BITS: begin
                if (in_rdy && !in_vld) begin
                    state_nxt = END;
                    err_nxt   = 1'b1;
                end else if (sym_end && bit_cnt == '0) begin
                    state_nxt = END;
                end
            end
            END:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A new symbol starts whenever we enter a timed state or a symbol
        // ends and the state repeats (next data bit).
        first_nxt = (state_nxt inside {DELIM, DATA0, RTCAL, TRCAL, BITS}) &&
                    ((state_nxt != state) || sym_end);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            preamble_r <= 1'b0;
            trcal_r    <= '0;
            bit_cnt    <= '0;
            err_r      <= 1'b0;
            sym_first  <= 1'b0;
        end else begin
            state     <= state_nxt;
            err_r     <= err_nxt;
            sym_first <= first_nxt;
            if (state == IDLE && start) begin
                preamble_r <= preamble;
                trcal_r    <= trcal_cycles;
                bit_cnt    <= cmd_len;
            end else if (consume && bit_cnt != '0) begin
                bit_cnt <= bit_cnt - LEN_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_pie_encoder.sv
// Bench for pie_encoder: a frame model builds the expected per-clock envelope,
// fetch strobes and end-of-frame flags from the symbol rules, and each
// scenario task compares the DUT against it clock by clock.
module tb_pie_encoder;

    localparam int TARI  = 25;
    localparam int D1    = 44;
    localparam int PW    = 12;
    localparam int DELIM = 25;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, preamble, in_dat, in_vld;
    logic [7:0] cmd_len;
    logic [8:0] trcal_cycles;
    logic       in_rdy, out_dat, busy, done, err;

    int checks   = 0;
    int failures = 0;

    bit q_out[$], q_rdy[$], q_done[$], q_err[$], q_fetch[$], q_dd[$], q_dv[$];

    pie_encoder dut (
        .clk(clk), .rst(rst), .start(start), .preamble(preamble),
        .cmd_len(cmd_len), .trcal_cycles(trcal_cycles), .in_dat(in_dat),
        .in_vld(in_vld), .in_rdy(in_rdy), .out_dat(out_dat), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic seg(input bit lvl, input int n);
        repeat (n) begin
            q_out.push_back(lvl); q_rdy.push_back(1'b0); q_done.push_back(1'b0);
            q_err.push_back(1'b0); q_fetch.push_back(1'b0);
            q_dd.push_back(1'b0); q_dv.push_back(1'b0);
        end
    endtask

    task automatic sym(input int len);
        seg(1'b1, len - PW);
        seg(1'b0, PW);
    endtask

    // Expected frame, indexed from the first clock after start is accepted.
    task automatic build(input bit pre, input int n, input int trc,
                         input bit [31:0] bits, input bit [31:0] vld);
        int idx;
        bit ab;
        q_out.delete(); q_rdy.delete(); q_done.delete(); q_err.delete();
        q_fetch.delete(); q_dd.delete(); q_dv.delete();
        seg(1'b0, DELIM);
        sym(TARI);
        sym(TARI + D1);
        if (pre) sym(trc);
        ab = 1'b0;
        for (int k = 0; k < n; k++) begin
            idx = q_out.size();
            if (!vld[k]) begin
                seg(1'b1, 1);
                ab = 1'b1;
            end else begin
                sym(bits[k] ? D1 : TARI);
            end
            q_rdy[idx] = 1'b1; q_fetch[idx] = 1'b1;
            q_dd[idx] = bits[k]; q_dv[idx] = vld[k];
            if (ab) break;
        end
        seg(1'b1, 1);
        q_done[q_out.size()-1] = 1'b1;
        q_err[q_out.size()-1]  = ab;
    endtask

    // Runs a frame against the model. cut >= 0 stops before checking that
    // clock (caller takes over); poke drives stray start pulses.
    task automatic run_frame(input string name, input bit pre, input int n,
                             input int trc, input bit [31:0] bits,
                             input bit [31:0] vld, input bit poke, input int cut);
        logic [3:0] got, exp;
        build(pre, n, trc, bits, vld);
        @(posedge clk); #1;
        start = 1'b1; preamble = pre; cmd_len = 8'(n); trcal_cycles = 9'(trc);
        @(posedge clk); #1;
        start = 1'b0; preamble = 1'($urandom);
        cmd_len = 8'($urandom); trcal_cycles = 9'($urandom);
        for (int i = 0; i < q_out.size(); i++) begin
            if (i == cut) return;
            if (q_fetch[i]) begin in_dat = q_dd[i]; in_vld = q_dv[i]; end
            else begin in_dat = 1'($urandom); in_vld = 1'($urandom); end
            start = poke && (q_done[i] || $urandom_range(0, 7) == 0);
            @(negedge clk);
            got = {out_dat, in_rdy, done, busy};
            exp = {q_out[i], q_rdy[i], q_done[i], 1'b1};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL %s cyc=%0d out/rdy/done/busy got=%b exp=%b", name, i, got, exp);
            end
            if (q_done[i]) begin
                checks++;
                if (err !== q_err[i]) begin
                    failures++;
                    $display("FAIL %s err got=%b exp=%b", name, err, q_err[i]);
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_dat, busy, done, in_rdy} !== 4'b1000) begin
            failures++;
            $display("FAIL %s post-frame out/busy/done/rdy got=%b exp=1000", name,
                     {out_dat, busy, done, in_rdy});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; preamble = 1'b0; cmd_len = '0;
        trcal_cycles = '0; in_dat = 1'b0; in_vld = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_dat, busy, done, err, in_rdy} !== 5'b10000) begin
            failures++;
            $display("FAIL reset out/busy/done/err/rdy got=%b exp=10000",
                     {out_dat, busy, done, err, in_rdy});
        end
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_framesync_empty();
        run_frame("fsync_len0", 1'b0, 0, 0, '0, '1, 1'b0, -1);
    endtask

    task automatic test_preamble_empty();
        run_frame("query_len0", 1'b1, 0, 150, '0, '1, 1'b0, -1);
    endtask

    task automatic test_two_bits();
        run_frame("bits_1_0", 1'b0, 2, 0, 32'b01, '1, 1'b0, -1);
    endtask

    task automatic test_underrun();
        run_frame("underrun", 1'b0, 3, 0, 32'($urandom), 32'hFFFF_FFFD, 1'b0, -1);
    endtask

    task automatic test_reset_mid_trcal();
        run_frame("rst_mid", 1'b1, 2, 150, 32'b11, '1, 1'b0,
                  DELIM + TARI + TARI + D1 + 40);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({out_dat, busy, done, in_rdy} !== 4'b1000) begin
            failures++;
            $display("FAIL rst_mid async out/busy/done/rdy got=%b exp=1000",
                     {out_dat, busy, done, in_rdy});
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL rst_mid held done/busy got=%b%b exp=00", done, busy);
            end
        end
        @(posedge clk); #1 rst = 1'b1;
        run_frame("after_rst", 1'b1, 3, 100, 32'b101, '1, 1'b0, -1);
    endtask

    task automatic test_start_ignored();
        run_frame("start_poke", 1'b1, 4, 60, 32'($urandom), '1, 1'b1, -1);
    endtask

    task automatic test_random();
        bit [31:0] vld;
        int n;
        for (int f = 0; f < 6; f++) begin
            n   = $urandom_range(0, 10);
            vld = '1;
            if ($urandom_range(0, 2) == 0 && n > 0) vld[$urandom_range(0, n-1)] = 1'b0;
            run_frame("random", 1'($urandom), n, $urandom_range(PW + 1, 200),
                      32'($urandom), vld, 1'($urandom), -1);
        end
    endtask

    initial begin
        test_reset();
        test_framesync_empty();
        test_preamble_empty();
        test_two_bits();
        test_underrun();
        test_reset_mid_trcal();
        test_start_ignored();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
